dsc_mul_ctrl: RTL

DSC_MUL_CTRL -- requirements
Module: dsc_mul_ctrl

---
 rtl/dsc_mul_ctrl.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/dsc_mul_ctrl.sv
// dsc_mul_ctrl: sequences one dsc_mul operation per operand tuple.
// Operand latch, clear, run with cycle count and timeout, and result hold.
module dsc_mul_ctrl #(
    parameter int NUM_BITS = 6,
    parameter int CYC_W    = 26,
    parameter int TIMEOUT  = 2**24 + 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NUM_BITS-1:0]   in_a,
    input  logic [NUM_BITS-1:0]   in_b,
    input  logic [NUM_BITS-1:0]   in_c,
    input  logic [NUM_BITS-1:0]   in_d,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*NUM_BITS-1:0] out_z,
    output logic [CYC_W-1:0]      out_cycles,
    output logic                  out_err,
    output logic                  mul_rst,
    output logic                  mul_en,
    output logic [NUM_BITS-1:0]   mul_a,
    output logic [NUM_BITS-1:0]   mul_b,
    output logic [NUM_BITS-1:0]   mul_c,
    output logic [NUM_BITS-1:0]   mul_d,
    input  logic [4*NUM_BITS-1:0] mul_z,
    input  logic                  mul_ov
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [CYC_W-1:0] LP_TMO_M1 = CYC_W'(TIMEOUT - 1);
    localparam logic [CYC_W-1:0] LP_TMO    = CYC_W'(TIMEOUT);

    state_t                r_state;
    state_t                w_state;
    logic [CYC_W-1:0]      r_cnt;
    logic [CYC_W-1:0]      w_cnt;
    logic [CYC_W-1:0]      w_cnt_inc;
    logic [4*NUM_BITS-1:0] r_z;
    logic [4*NUM_BITS-1:0] w_z;
    logic [CYC_W-1:0]      r_cyc;
    logic [CYC_W-1:0]      w_cyc;
    logic                  r_err;
    logic                  w_err;
    logic [NUM_BITS-1:0]   r_a;
    logic [NUM_BITS-1:0]   r_b;
    logic [NUM_BITS-1:0]   r_c;
    logic [NUM_BITS-1:0]   r_d;
    logic [NUM_BITS-1:0]   w_a;
    logic [NUM_BITS-1:0]   w_b;
    logic [NUM_BITS-1:0]   w_c;
    logic [NUM_BITS-1:0]   w_d;
    logic                  r_in_ready;
    logic                  w_in_ready;
    logic                  r_out_valid;
    logic                  w_out_valid;
    logic                  r_mul_rst;
    logic                  w_mul_rst;
    logic                  r_mul_en;
    logic                  w_mul_en;
    logic                  w_zero;

    assign w_zero = (in_a == '0) || (in_b == '0) ||
                    (in_c == '0) || (in_d == '0);

    // Counter value for this RUN cycle, pinned at all-ones.
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

    // Next state and next value of every registered output.
    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_z         = r_z;
        w_cyc       = r_cyc;
        w_err       = r_err;
        w_a         = r_a;
        w_b         = r_b;
        w_c         = r_c;
        w_d         = r_d;
        w_in_ready  = r_in_ready;
        w_out_valid = r_out_valid;
        w_mul_rst   = r_mul_rst;
        w_mul_en    = r_mul_en;
        unique case (r_state)
            S_IDLE: begin
                if (in_valid && r_in_ready) begin
                    w_a        = in_a;
                    w_b        = in_b;
                    w_c        = in_c;
                    w_d        = in_d;
                    w_cnt      = '0;
                    w_in_ready = 1'b0;
                    if (w_zero) begin
                        w_state     = S_DONE;
                        w_z         = '0;
                        w_cyc       = '0;
                        w_err       = 1'b0;
                        w_out_valid = 1'b1;
                    end else begin
                        w_state = S_CLEAR;
                    end
                end
            end
            S_CLEAR: begin
                w_state   = S_RUN;
                w_mul_rst = 1'b0;
                w_mul_en  = 1'b1;
            end
            S_RUN: begin
                w_cnt = w_cnt_inc;
                if (mul_ov) begin
                    w_state     = S_DONE;
                    w_z         = mul_z;
                    w_cyc       = w_cnt_inc;
                    w_err       = 1'b0;
                    w_out_valid = 1'b1;
                    w_mul_rst   = 1'b1;
                    w_mul_en    = 1'b0;
                end else if (r_cnt == LP_TMO_M1) begin
                    w_state     = S_DONE;
                    w_z         = '0;
                    w_cyc       = LP_TMO;
                    w_err       = 1'b1;
                    w_out_valid = 1'b1;
                    w_mul_rst   = 1'b1;
                    w_mul_en    = 1'b0;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state     = S_IDLE;
                    w_out_valid = 1'b0;
                    w_in_ready  = 1'b1;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_z         <= '0;
            r_cyc       <= '0;
            r_err       <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_c         <= '0;
            r_d         <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_mul_rst   <= 1'b1;
            r_mul_en    <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_z         <= w_z;
            r_cyc       <= w_cyc;
            r_err       <= w_err;
            r_a         <= w_a;
            r_b         <= w_b;
            r_c         <= w_c;
            r_d         <= w_d;
            r_in_ready  <= w_in_ready;
            r_out_valid <= w_out_valid;
            r_mul_rst   <= w_mul_rst;
            r_mul_en    <= w_mul_en;
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_z      = r_z;
    assign out_cycles = r_cyc;
    assign out_err    = r_err;
    assign mul_rst    = r_mul_rst;
    assign mul_en     = r_mul_en;
    assign mul_a      = r_a;
    assign mul_b      = r_b;
    assign mul_c      = r_c;
    assign mul_d      = r_d;

endmodule
